// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: button indices,
// default timing constants and the per-channel state encoding.
package btn_pkg;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_MIDDLE = 4;

    localparam int DEF_TICK_CYCLES    = 100000;
    localparam int DEF_DEBOUNCE_TICKS = 20;
    localparam int DEF_LONG_TICKS     = 1000;
    localparam int DEF_REPEAT_TICKS   = 200;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t ST_IDLE    = 2'd0;
    localparam btn_state_t ST_PRESSED = 2'd1;
    localparam btn_state_t ST_HELD    = 2'd2;

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, tick-based debounce and IDLE/PRESSED/HELD
// state machine. Auto-repeat in HELD is built only when BTN_REPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int LONG_TICKS     = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    logic              sync_q1;
    logic              sync_q2;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    btn_state_t        state;
    logic              accept;
    logic              accept_press;
    logic              accept_release;
    logic              hold_done;
    logic              repeat_fire;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two
    // synchroniser stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // The tick that would bring the counter to DEBOUNCE_TICKS is the one that flips the level.
    assign accept         = tick && (sync_q2 != level) && (db_cnt == DB_W'(DEBOUNCE_TICKS - 1));
    assign accept_press   = accept && !level;
    assign accept_release = accept && level;
    assign hold_done      = tick && (state == ST_PRESSED) && (hold_cnt == HOLD_W'(LONG_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync_q2 == level) begin
            db_cnt <= '0;
        end else if (accept) begin
            db_cnt <= '0;
            level  <= ~level;
        end else if (tick) begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);

    logic [REP_W-1:0] rep_cnt;

    assign repeat_fire = tick && (state == ST_HELD) && !accept_release
                         && (rep_cnt == REP_W'(REPEAT_TICKS - 1));

    // Leaving HELD (release or reset) zeroes the counter, so each entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst || (state != ST_HELD) || repeat_fire) begin
            rep_cnt <= '0;
        end else if (tick) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= accept_press || repeat_fire;
            release_pulse <= accept_release;
            long_pulse    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    if (accept_press) state <= ST_PRESSED;
                end
                ST_PRESSED: begin
                    if (accept_release) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end else if (hold_done) begin
                        state      <= ST_HELD;
                        hold_cnt   <= HOLD_W'(LONG_TICKS);
                        long_pulse <= 1'b1;
                    end else if (tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (accept_release) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Board push-button front end: shared 1 ms tick divider plus NBTN conditioned
// channels. Define BTN_REPEAT_EN to enable auto-repeat of btn_press while held.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NBTN           = 5,
    parameter int TICK_CYCLES    = DEF_TICK_CYCLES,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int LONG_TICKS     = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NBTN-1:0] btn_long,
    output logic            tick
);

    localparam int TICK_W = $clog2(TICK_CYCLES + 1);

    logic [TICK_W-1:0] tick_cnt;

    assign tick = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_channel (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .long_pulse    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short timing parameters; expected
// pulse events (cycle since reset plus output vectors) are hand-computed.
module tb_button_conditioner;

    localparam int NBTN = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;
    logic [NBTN-1:0] btn_long;
    logic            tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int first_tick;

    typedef struct {
        int              cyc;
        logic [NBTN-1:0] press;
        logic [NBTN-1:0] rel;
        logic [NBTN-1:0] lng;
        logic [NBTN-1:0] level;
    } ev_t;

    ev_t exp_q[$];

    button_conditioner #(
        .NBTN           (NBTN),
        .TICK_CYCLES    (4),
        .DEBOUNCE_TICKS (3),
        .LONG_TICKS     (10),
        .REPEAT_TICKS   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset edge; matches the tick phase (tick when cyc % 4 == 3).
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [NBTN-1:0] p, input logic [NBTN-1:0] r,
                           input logic [NBTN-1:0] l, input logic [NBTN-1:0] lv);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.level = lv;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every pulse the DUT presents must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && ((|btn_press) || (|btn_release) || (|btn_long))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: press=%b release=%b long=%b at cycle %0d, expected none",
                         btn_press, btn_release, btn_long, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_cycle",   cyc,         e.cyc);
                check("event_press",   btn_press,   e.press);
                check("event_release", btn_release, e.rel);
                check("event_long",    btn_long,    e.lng);
                check("event_level",   btn_level,   e.level);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        btn_raw = '1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_outputs", {btn_level, btn_press, btn_release, btn_long, tick}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        btn_raw = '0;

        first_tick = -1;
        for (int i = 0; i < 8 && first_tick < 0; i++) begin
            @(negedge clk);
            if (tick) first_tick = cyc;
        end
        check("first_tick_cycle", first_tick, 32'd3);

        // Clean press/release on channel 0: sync at 12, ticks 15,19,23.
        wait_cyc(10);
        btn_raw[0] = 1'b1;
        push_ev(24, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
        wait_cyc(46);
        btn_raw[0] = 1'b0;
        push_ev(60, 5'b00000, 5'b00001, 5'b00000, 5'b00000);

        // Two-tick glitch on channel 2 must be swallowed.
        wait_cyc(70);
        btn_raw[2] = 1'b1;
        wait_cyc(78);
        btn_raw[2] = 1'b0;
        wait_cyc(85);
        check("glitch_level", btn_level[2], 32'd0);

        // Long press on channel 4: press 104, long 10 ticks later at 144.
        wait_cyc(90);
        btn_raw[4] = 1'b1;
        push_ev(104, 5'b10000, 5'b00000, 5'b00000, 5'b10000);
        push_ev(144, 5'b00000, 5'b00000, 5'b10000, 5'b10000);
        wait_cyc(150);
        btn_raw[4] = 1'b0;
        push_ev(164, 5'b00000, 5'b10000, 5'b00000, 5'b00000);

        // Channels 1 and 3 together.
        wait_cyc(180);
        btn_raw[1] = 1'b1;
        btn_raw[3] = 1'b1;
        push_ev(192, 5'b01010, 5'b00000, 5'b00000, 5'b01010);
        wait_cyc(200);
        btn_raw[1] = 1'b0;
        btn_raw[3] = 1'b0;
        push_ev(212, 5'b00000, 5'b01010, 5'b00000, 5'b00000);

        // Channel 0 held through long press, then reset while still held.
        wait_cyc(230);
        btn_raw[0] = 1'b1;
        push_ev(244, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
        push_ev(284, 5'b00000, 5'b00000, 5'b00001, 5'b00001);
`ifdef BTN_REPEAT_EN
        push_ev(300, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
        push_ev(316, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
`endif
        wait_cyc(319);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_ev(12, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
        @(negedge clk);
        check("midreset_outputs", {btn_level, btn_press, btn_release, btn_long, tick}, 32'd0);
        check("midreset_pending", exp_q.size(), 32'd1);
        wait_cyc(30);
        btn_raw[0] = 1'b0;
        push_ev(44, 5'b00000, 5'b00001, 5'b00000, 5'b00000);

        wait_cyc(60);
        @(negedge clk);
        check("missing_events", exp_q.size(), 32'd0);
        check("final_level", btn_level, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
